// File: rtl/shift_ser_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and sends it MSB first, one bit per ser_en strobe, each bit held BIT_CYCLES clocks.
module shift_ser_tx #(
    parameter int WIDTH      = 10,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready;
    // load_data is sampled only on that edge and the source holds it until then.

    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [DIV_W-1:0] div_cnt, div_cnt_next;

    logic load_ready_next, ser_out_next, ser_en_next, busy_next, done_next;
    logic accept, bit_end, word_end;

    assign accept   = (state == IDLE) && load_valid && load_ready;
    assign bit_end  = (div_cnt == DIV_LAST);
    assign word_end = bit_end && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            div_cnt <= div_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        div_cnt_next = div_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = SHIFT;
                    shreg_next   = load_data;
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    if (word_end) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        shreg_next   = {shreg[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_next = div_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; the current MSB of shreg is already
    // on ser_out, so the following bit comes from shreg[WIDTH-2].
    always_comb begin
        load_ready_next = 1'b0;
        ser_out_next    = 1'b0;
        ser_en_next     = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ser_out_next = load_data[WIDTH-1];
                    ser_en_next  = 1'b1;
                    busy_next    = 1'b1;
                end else begin
                    load_ready_next = 1'b1;
                end
            end
            SHIFT: begin
                if (word_end) begin
                    load_ready_next = 1'b1;
                end else begin
                    busy_next = 1'b1;
                    if (bit_end) begin
                        ser_out_next = shreg[WIDTH-2];
                        ser_en_next  = 1'b1;
                        done_next    = (bit_cnt == BIT_PENULT);
                    end else begin
                        ser_out_next = ser_out;
                    end
                end
            end
            default: load_ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready <= 1'b0;
            ser_out    <= 1'b0;
            ser_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_ready <= load_ready_next;
            ser_out    <= ser_out_next;
            ser_en     <= ser_en_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule
